reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_pkg.sv | 33 +++
 rtl/reg_scoreboard.sv | 81 ++++++++
 rtl/reg_file.sv | 84 ++++++++
 tb/tb_reg_file.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared register-file constants and read-source encoding.
// Configuration macro: REG_FILE_BYPASS_EN (write-to-read forwarding, used by reg_file/reg_scoreboard).
package reg_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // Where a read port takes its value from in the current cycle.
    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_REG    = 2'd1,
        SRC_BYPASS = 2'd2
    } rd_src_e;

    // Chooses a read port's source; r0 always reads zero, forwarding only when enabled.
    function automatic rd_src_e pick_src(
        input logic rd_is_zero,
        input logic fwd_hit,
        input logic fwd_enable
    );
        rd_src_e src;
        if (rd_is_zero) begin
            src = SRC_ZERO;
        end else if (fwd_enable && fwd_hit) begin
            src = SRC_BYPASS;
        end else begin
            src = SRC_REG;
        end
        return src;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits and the decode stall they produce.
// Configuration macro: REG_FILE_BYPASS_EN (a forwarded operand no longer stalls).
module reg_scoreboard
    import reg_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              stall
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic             w_rs_pend;
    logic             w_rt_pend;
    logic             w_rs_fwd;
    logic             w_rt_fwd;

    // Writeback clears first, issue sets last so a same-edge new producer wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (wr_en) begin
                r_busy[wr_addr] <= 1'b0;
            end
            if (issue_en && (issue_addr != '0)) begin
                r_busy[issue_addr] <= 1'b1;
            end
            r_busy[0] <= 1'b0;
        end
    end

    // Forward-hit detection for each read port.
    always_comb begin
        w_rs_fwd = 1'b0;
        w_rt_fwd = 1'b0;
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && (wr_addr == rs_addr)) begin
            w_rs_fwd = 1'b1;
        end else begin
            w_rs_fwd = 1'b0;
        end
        if (wr_en && (wr_addr == rt_addr)) begin
            w_rt_fwd = 1'b1;
        end else begin
            w_rt_fwd = 1'b0;
        end
`else
        w_rs_fwd = 1'b0;
        w_rt_fwd = 1'b0;
`endif
    end

    // A source is pending when its register is busy and not being forwarded now.
    always_comb begin
        w_rs_pend = 1'b0;
        w_rt_pend = 1'b0;
        if ((rs_addr != '0) && r_busy[rs_addr] && !w_rs_fwd) begin
            w_rs_pend = 1'b1;
        end else begin
            w_rs_pend = 1'b0;
        end
        if ((rt_addr != '0) && r_busy[rt_addr] && !w_rt_fwd) begin
            w_rt_pend = 1'b1;
        end else begin
            w_rt_pend = 1'b0;
        end
    end

    assign stall = w_rs_pend | w_rt_pend;

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with r0 hardwired to zero and a busy scoreboard.
// Configuration macro: REG_FILE_BYPASS_EN (forward wr_data to matching read ports).
module reg_file
    import reg_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              stall
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef REG_FILE_BYPASS_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    logic [DATA_W-1:0] r_regs [DEPTH];
    rd_src_e           w_rs_src;
    rd_src_e           w_rt_src;

    // Data array; r0 is never written so it stays at its reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en && (wr_addr != '0)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Read-source selection for both ports.
    always_comb begin
        w_rs_src = pick_src(rs_addr == '0, wr_en && (wr_addr == rs_addr), FWD_ON);
        w_rt_src = pick_src(rt_addr == '0, wr_en && (wr_addr == rt_addr), FWD_ON);
    end

    // Combinational read muxes.
    always_comb begin
        rs_data = {DATA_W{1'b0}};
        rt_data = {DATA_W{1'b0}};
        case (w_rs_src)
            SRC_REG:    rs_data = r_regs[rs_addr];
            SRC_BYPASS: rs_data = wr_data;
            SRC_ZERO:   rs_data = {DATA_W{1'b0}};
            default:    rs_data = {DATA_W{1'b0}};
        endcase
        case (w_rt_src)
            SRC_REG:    rt_data = r_regs[rt_addr];
            SRC_BYPASS: rt_data = wr_data;
            SRC_ZERO:   rt_data = {DATA_W{1'b0}};
            default:    rt_data = {DATA_W{1'b0}};
        endcase
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .stall      (stall)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reads, r0, scoreboard, same-edge issue/writeback, forwarding, async reset.
// Expectations follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        stall;

    int n_checks;
    int n_fails;

    reg_file #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        issue_en = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        reset      = 1'b1;
        rs_addr    = 5'd5;
        rt_addr    = 5'd0;
        wr_en      = 1'b0;
        wr_addr    = 5'd0;
        wr_data    = 32'h0;
        issue_en   = 1'b0;
        issue_addr = 5'd0;

        #12;
        chk("rst_rs",    rs_data, 32'h0);
        chk("rst_rt",    rt_data, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_rs", rs_data, 32'h0);

        // Write then read r3; r0 writes discarded
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        step();
        idle();
        rs_addr = 5'd3; rt_addr = 5'd0;
        #1;
        chk("r3_read",  rs_data, 32'hDEADBEEF);
        chk("rt_r0",    rt_data, 32'h0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        step();
        idle();
        rs_addr = 5'd0;
        #1;
        chk("r0_zero",  rs_data, 32'h0);

        // Issue alone never changes data
        issue_en = 1'b1; issue_addr = 5'd3;
        step();
        idle();
        rs_addr = 5'd3;
        #1;
        chk("issue_keeps_data", rs_data, 32'hDEADBEEF);
        chk("issue_r3_stall",   32'(stall), 32'h1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        step();
        idle();
        #1;
        chk("r3_release", 32'(stall), 32'h0);

        // Issue r7, writeback clears busy
        issue_en = 1'b1; issue_addr = 5'd7;
        step();
        idle();
        rs_addr = 5'd7;
        #1;
        chk("r7_stall", 32'(stall), 32'h1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        step();
        idle();
        #1;
        chk("r7_stall_clr", 32'(stall), 32'h0);
        chk("r7_data",      rs_data, 32'h55);

        // Same-edge issue and writeback: new producer wins, data still written
        issue_en = 1'b1; issue_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA;
        step();
        idle();
        rs_addr = 5'd0; rt_addr = 5'd9;
        #1;
        chk("r9_busy",  32'(stall), 32'h1);
        chk("r9_data",  rt_data, 32'hAA);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hAB;
        step();
        idle();
        #1;
        chk("r9_clr",   32'(stall), 32'h0);
        chk("r9_data2", rt_data, 32'hAB);

        // Forwarding behaviour on a pending register
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h11;
        step();
        idle();
        issue_en = 1'b1; issue_addr = 5'd4;
        step();
        idle();
        rs_addr = 5'd4; rt_addr = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("fwd_data",  rs_data, 32'h77);
        chk("fwd_stall", 32'(stall), 32'h0);
`else
        chk("nofwd_data",  rs_data, 32'h11);
        chk("nofwd_stall", 32'(stall), 32'h1);
`endif
        step();
        idle();
        #1;
        chk("r4_after",       rs_data, 32'h77);
        chk("r4_stall_after", 32'(stall), 32'h0);

        // Async reset mid-cycle abandons busy bits and clears data
        issue_en = 1'b1; issue_addr = 5'd2;
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        step();
        idle();
        rs_addr = 5'd2; rt_addr = 5'd6;
        #1;
        chk("pre_rst_stall", 32'(stall), 32'h1);
        chk("pre_rst_r6",    rt_data, 32'h66);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_rs",    rs_data, 32'h0);
        chk("async_rst_rt",    rt_data, 32'h0);
        chk("async_rst_stall", 32'(stall), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("after_rst_r6",    rt_data, 32'h0);
        chk("after_rst_stall", 32'(stall), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
